sl_bus_scheduler: RTL and testbench

SL_BUS_SCHEDULER -- requirements
Module: sl_bus_scheduler

---
 rtl/sl_bus_scheduler_if.sv | 31 +++
 rtl/sl_bus_scheduler.sv | 132 +++++++++++++
 tb/tb_sl_bus_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_bus_scheduler_if.sv
// Signal bundle shared by the slave-bus scheduler, the per-port FIFOs and the
// downstream byte sink. The scheduler uses the master view.
interface sl_bus_scheduler_if #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2
);
   logic [NUM_PORTS-1:0] sl_arb_request;
   logic [NUM_PORTS-1:0] sl_arb_grant;
   logic                 sl_latch_tail;
   logic [8:0]           sl_addr;
   logic [8:0]           sl_tail;
   logic [8:0]           sl_data;
   logic [7:0]           out_data;
   logic                 out_frame_end;
   logic                 out_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [PORT_BITS-1:0] out_src;

   modport master (
      input  sl_arb_request, sl_tail, sl_data, out_ready,
      output sl_arb_grant, sl_latch_tail, sl_addr,
             out_data, out_frame_end, out_last, out_valid, out_src
   );

   modport slave (
      output sl_arb_request, sl_tail, sl_data, out_ready,
      input  sl_arb_grant, sl_latch_tail, sl_addr,
             out_data, out_frame_end, out_last, out_valid, out_src
   );
endinterface

// File: rtl/sl_bus_scheduler.sv
// Round-robin scheduler that grants one FIFO port at a time, drains the tail
// count captured at grant time downstream, then tells the FIFO to release it.
module sl_bus_scheduler #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   sl_bus_scheduler_if.master         bus,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // Pointer starts at the last port so that port 0 searches first.
   localparam logic [PORT_BITS-1:0] RR_INIT = PORT_BITS'(NUM_PORTS - 1);

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [PORT_BITS-1:0] winner_q, winner_d;
   logic [PORT_BITS-1:0] rr_q, rr_d;
   logic [8:0]           idx_q, idx_d;
   logic [8:0]           tail_q, tail_d;

   logic [PORT_BITS-1:0] pick;
   logic [PORT_BITS-1:0] cand;
   logic                 pick_found;
   logic                 last_byte;

   // Search (rr+1) mod NUM_PORTS upward with wrap; the first requester wins.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = PORT_BITS'((int'(rr_q) + k) % NUM_PORTS);
         if (!pick_found && bus.sl_arb_request[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // tail_q is at least 1 whenever XFER is entered, so the subtraction never wraps there.
   assign last_byte = (idx_q == tail_q - 9'd1);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      winner_d = winner_q;
      rr_d     = rr_q;
      idx_d    = idx_q;
      tail_d   = tail_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               winner_d = pick;
               grant_d  = NUM_PORTS'(1) << pick;
               state_d  = CAPTURE;
            end
         end
         CAPTURE: begin
            tail_d  = bus.sl_tail;
            idx_d   = '0;
            state_d = (bus.sl_tail == 9'd0) ? RELEASE : XFER;
         end
         XFER: begin
            if (bus.out_ready) begin
               if (last_byte) state_d = RELEASE;
               else           idx_d   = idx_q + 9'd1;
            end
         end
         RELEASE: begin
            rr_d    = winner_q;
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         winner_q <= '0;
         rr_q     <= RR_INIT;
         idx_q    <= '0;
         tail_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         winner_q <= winner_d;
         rr_q     <= rr_d;
         idx_q    <= idx_d;
         tail_q   <= tail_d;
      end
   end

   // Outputs are decoded from registered state, so reset clears them at once.
   always_comb begin
      bus.sl_arb_grant  = grant_q;
      bus.sl_latch_tail = (state_q == RELEASE);
      bus.sl_addr       = '0;
      bus.out_valid     = 1'b0;
      bus.out_data      = '0;
      bus.out_frame_end = 1'b0;
      bus.out_last      = 1'b0;
      bus.out_src       = '0;
      if (state_q == XFER) begin
         bus.sl_addr       = idx_q;
         bus.out_valid     = 1'b1;
         bus.out_data      = bus.sl_data[7:0];
         bus.out_frame_end = bus.sl_data[8];
         bus.out_last      = last_byte;
         bus.out_src       = winner_q;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sl_bus_scheduler.sv
// Scoreboard bench: per-port FIFO model feeds the scheduler, stimulus queues
// expected grants and bytes, and a negedge monitor compares what comes out.
module tb_sl_bus_scheduler;
   localparam int NP = 4;
   localparam int PB = 2;

   typedef struct packed {
      logic [PB-1:0] src;
      logic [8:0]    addr;
      logic [7:0]    data;
      logic          fe;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic ready = 1'b1;

   sl_bus_scheduler_if #(.NUM_PORTS(NP), .PORT_BITS(PB)) bus ();

   sl_bus_scheduler #(.NUM_PORTS(NP), .PORT_BITS(PB)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.master),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [8:0]    mem [NP][512];
   int            count [NP];
   int            cap [NP];
   logic [NP-1:0] force_on = '0;
   logic [NP-1:0] mask_off = '0;
   int            refill_port = -1;

   beat_t exp_q[$];
   int    exp_g[$];
   int    model_rr = NP - 1;

   int accepts = 0, valids = 0, latches = 0, gnt_len = 0, last_gnt_len = 0;
   int ready_mode = 0;
   int pat_i = 0;
   logic [4:0] ready_pat = 5'b10100;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int gidx(input logic [NP-1:0] g);
      for (int i = 0; i < NP; i++) if (g[i]) return i;
      return -1;
   endfunction

   // Round-robin rule: first requester at or after rr+1, wrapping at NP.
   function automatic int pick(input int rr, input logic [NP-1:0] mask);
      for (int k = 1; k <= NP; k++) begin
         int p;
         p = (rr + k) % NP;
         if (mask[p]) return p;
      end
      return -1;
   endfunction

   // ---------------- FIFO-side model ----------------
   always_comb begin
      for (int p = 0; p < NP; p++)
         bus.sl_arb_request[p] = (force_on[p] || count[p] != 0) && !mask_off[p];
   end

   always_comb begin
      bus.sl_tail = '0;
      bus.sl_data = '0;
      for (int p = 0; p < NP; p++) begin
         if (bus.sl_arb_grant[p]) begin
            bus.sl_tail = 9'(count[p]);
            bus.sl_data = mem[p][bus.sl_addr];
         end
      end
   end

   assign bus.out_ready = ready;

   logic [NP-1:0] fm_prev_g = '0;
   int            fm_p;
   always @(posedge clk) begin
      #1;
      if (bus.sl_arb_grant != '0 && fm_prev_g == '0) begin
         fm_p      = gidx(bus.sl_arb_grant);
         cap[fm_p] = count[fm_p];
      end
      if (bus.sl_latch_tail) begin
         fm_p = gidx(bus.sl_arb_grant);
         if (fm_p >= 0) begin
            for (int i = 0; i < 512; i++)
               mem[fm_p][i] = (i + cap[fm_p] < 512) ? mem[fm_p][i + cap[fm_p]] : 9'h0;
            count[fm_p]    = count[fm_p] - cap[fm_p];
            force_on[fm_p] = 1'b0;
            if (fm_p == refill_port) begin
               count[fm_p] = count[fm_p] + 1;
               refill_port = -1;
            end
         end
      end
      fm_prev_g = bus.sl_arb_grant;
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: ready = 1'($urandom_range(0, 1));
         2: begin
            if (bus.out_valid) begin
               ready = (pat_i < 5) ? ready_pat[pat_i] : 1'b1;
               pat_i++;
            end else begin
               ready = 1'b0;
            end
         end
         default: ready = 1'b1;
      endcase
   end

   // ---------------- Monitor / scoreboard ----------------
   beat_t         mon_act;
   beat_t         prev_beat = '0;
   logic          prev_stall = 1'b0;
   logic [NP-1:0] mon_prev_g = '0;
   always @(negedge clk) begin
      mon_act = '{src: bus.out_src, addr: bus.sl_addr, data: bus.out_data,
                  fe: bus.out_frame_end, last: bus.out_last};
      if (bus.out_valid) valids++;
      if (bus.sl_latch_tail) latches++;
      if (prev_stall && bus.out_valid) check("stall_hold", 32'(mon_act), 32'(prev_beat));
      if (bus.out_valid && bus.out_ready) begin
         accepts++;
         if (exp_q.size() == 0) check("unexpected_beat", 32'(mon_act), 32'hFFFF_FFFF);
         else                   check("beat", 32'(mon_act), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_beat  = mon_act;

      if (bus.sl_arb_grant != '0 && mon_prev_g == '0) begin
         check("grant_onehot", $countones(bus.sl_arb_grant), 1);
         if (exp_g.size() == 0) check("unexpected_grant", gidx(bus.sl_arb_grant), 32'hFFFF_FFFF);
         else                   check("grant_port", gidx(bus.sl_arb_grant), exp_g.pop_front());
         gnt_len = 0;
      end
      if (bus.sl_arb_grant != '0 && mon_prev_g != '0 && bus.sl_arb_grant != mon_prev_g)
         check("grant_stable", bus.sl_arb_grant, mon_prev_g);
      if (bus.sl_arb_grant != '0) gnt_len++;
      else if (mon_prev_g != '0)  last_gnt_len = gnt_len;
      mon_prev_g = bus.sl_arb_grant;
   end

   // ---------------- Stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input int p, input int n);
      for (int i = 0; i < n; i++) mem[p][i] = 9'($urandom);
      count[p] = n;
   endtask

   task automatic push_frame(input int p, input int start, input int n);
      logic [8:0] e;
      for (int i = 0; i < n; i++) begin
         e = mem[p][start + i];
         exp_q.push_back('{src: PB'(p), addr: 9'(i), data: e[7:0], fe: e[8], last: (i == n - 1)});
      end
   endtask

   task automatic serve(input int p, input int n);
      exp_g.push_back(p);
      push_frame(p, 0, n);
      model_rr = p;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while ((busy || bus.sl_arb_request != '0 || exp_q.size() != 0 || exp_g.size() != 0)
             && n < budget) begin
         tick();
         n++;
      end
      check({name, "_drained"}, {busy, exp_q.size() != 0, exp_g.size() != 0}, 0);
      exp_q.delete();
      exp_g.delete();
   endtask

   // ---------------- Test sequence ----------------
   initial begin
      int w, a, v, l, served0;
      logic [NP-1:0] m;

      repeat (2) tick();
      check("rst_grant", bus.sl_arb_grant, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_latch", bus.sl_latch_tail, 0);
      check("rst_addr", bus.sl_addr, 0);
      check("rst_out", {bus.out_data, bus.out_src, bus.out_last, bus.out_frame_end}, 0);
      rst = 1'b0;
      tick();

      // Fairness: all ports request; port 0 refills once so it competes again.
      load(0, 2); count[0] = 1;
      load(1, 1); load(2, 1); load(3, 1);
      refill_port = 0;
      m = '1; served0 = 0;
      repeat (5) begin
         w = pick(model_rr, m);
         exp_g.push_back(w);
         push_frame(w, (w == 0) ? served0 : 0, 1);
         model_rr = w;
         if (w == 0 && served0 == 0) served0 = 1;
         else m[w] = 1'b0;
      end
      check("latency_pre", bus.sl_arb_grant, 0);
      @(negedge clk);
      check("latency_grant", bus.sl_arb_grant, 4'b0001);
      wait_done("fair", 200);

      // Reset in the middle of a 10-byte frame on port 3.
      load(3, 10);
      serve(3, 10);
      a = 0;
      while (accepts < 5 + a && a < 1) begin end
      a = accepts;
      for (int n = 0; n < 100 && accepts - a < 5; n++) tick();
      check("pre_reset_accepts", accepts - a, 5);
      l = latches;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_grant", bus.sl_arb_grant, 0);
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_latch", bus.sl_latch_tail, 0);
      exp_q.delete();
      exp_g.delete();
      model_rr = NP - 1;
      repeat (2) tick();
      check("midrst_no_release", latches - l, 0);
      load(0, 2);
      m = 4'b1001;
      while (m != '0) begin
         w = pick(model_rr, m);
         serve(w, count[w]);
         m[w] = 1'b0;
      end
      rst = 1'b0;
      wait_done("post_reset", 200);

      // Single port with explicit frame-boundary data.
      mem[2][0] = 9'h011; mem[2][1] = 9'h022; mem[2][2] = 9'h1AA;
      count[2] = 3;
      serve(pick(model_rr, 4'b0100), 3);
      l = latches;
      check("single_pre", bus.sl_arb_grant, 0);
      @(negedge clk);
      check("single_grant", bus.sl_arb_grant, 4'b0100);
      wait_done("single", 100);
      check("single_latch", latches - l, 1);
      check("single_len", last_gnt_len, 5);
      check("single_idle", {busy, bus.sl_arb_grant}, 0);

      // Back-pressure with ready pattern 0,0,1,0,1.
      ready_mode = 2; pat_i = 0;
      load(1, 2);
      serve(pick(model_rr, 4'b0010), 2);
      a = accepts; v = valids;
      wait_done("bp", 100);
      check("bp_accepts", accepts - a, 2);
      check("bp_valid_cycles", valids - v, 5);
      ready_mode = 0;

      // Zero tail: forced request with an empty FIFO.
      force_on[1] = 1'b1;
      exp_g.push_back(pick(model_rr, 4'b0010));
      model_rr = 1;
      v = valids; l = latches;
      wait_done("zero", 100);
      check("zero_valid", valids - v, 0);
      check("zero_latch", latches - l, 1);
      check("zero_len", last_gnt_len, 2);

      // Request drops after the first accepted byte.
      load(3, 4);
      serve(pick(model_rr, 4'b1000), 4);
      a = accepts; l = latches;
      for (int n = 0; n < 50 && accepts == a; n++) tick();
      mask_off[3] = 1'b1;
      wait_done("drop", 100);
      check("drop_accepts", accepts - a, 4);
      check("drop_latch", latches - l, 1);
      mask_off = '0;

      // Maximum tail of 511 under random back-pressure.
      ready_mode = 1;
      load(1, 511);
      serve(pick(model_rr, 4'b0010), 511);
      a = accepts;
      wait_done("max", 4000);
      check("max_accepts", accepts - a, 511);

      // Random port sets, lengths and back-pressure.
      repeat (25) begin
         m = NP'($urandom_range(1, (1 << NP) - 1));
         for (int p = 0; p < NP; p++) if (m[p]) load(p, $urandom_range(1, 6));
         while (m != '0) begin
            w = pick(model_rr, m);
            serve(w, count[w]);
            m[w] = 1'b0;
         end
         wait_done("rand", 400);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
